// File: rtl/present_dom_pkg.sv
// Shared constants and types for the masked PRESENT sbox-layer sequencer.
package present_dom_pkg;

    localparam int SBOX_LAT = 3;
    localparam int NIBBLES  = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_e;

    typedef logic [3:0] nib_idx_t;

endpackage

// File: rtl/sbox_tag_pipe.sv
// Valid/index delay line that shadows the external masked sbox latency so
// each returning result can be written back into the right nibble slot.
module sbox_tag_pipe
    import present_dom_pkg::*;
#(
    parameter int DEPTH = SBOX_LAT
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push_vld,
    input  nib_idx_t push_idx,
    output logic     ret_vld,
    output nib_idx_t ret_idx,
    output logic     pending
);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    nib_idx_t         idx_q [DEPTH];
    nib_idx_t         idx_d [DEPTH];

    // Shift the tags one stage per cycle; stage 0 takes the newly issued nibble.
    always_comb begin
        vld_d[0] = push_vld;
        idx_d[0] = push_idx;
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i] = vld_q[i-1];
            idx_d[i] = idx_q[i-1];
        end
    end

    // Tag registers; reset drops every in-flight nibble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < DEPTH; i++) begin
                idx_q[i] <= idx_d[i];
            end
        end
    end

    assign ret_vld = vld_q[DEPTH-1];
    assign ret_idx = idx_q[DEPTH-1];

    // Tags still in flight after this cycle's retirement (last stage excluded,
    // it is written back at the end of the current cycle).
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            pending = pending | vld_q[i];
        end
    end

endmodule

// File: rtl/present_sbox_layer_seq.sv
// Feeds a 64-bit two-share PRESENT state nibble by nibble through an external
// pipelined masked sbox and reassembles the result shares. Share 0 and share 1
// travel through strictly separate registers and muxes.
module present_sbox_layer_seq #(
    parameter int SBOX_LAT = present_dom_pkg::SBOX_LAT,
    parameter int NIBBLES  = present_dom_pkg::NIBBLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_s0,
    input  logic [63:0] in_s1,
    output logic        rnd_req,
    input  logic        rnd_valid,
    input  logic        rnd,
    output logic [3:0]  sb_x_s0,
    output logic [3:0]  sb_x_s1,
    output logic        sb_r,
    input  logic [3:0]  sb_y_s0,
    input  logic [3:0]  sb_y_s1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_s0,
    output logic [63:0] out_s1
);

    import present_dom_pkg::*;

    state_e      state_q, state_d;
    nib_idx_t    idx_q, idx_d;
    logic [63:0] sh0_q, sh0_d, sh1_q, sh1_d;
    logic [63:0] res0_q, res0_d, res1_q, res1_d;
    logic        issue;
    logic        ret_vld;
    nib_idx_t    ret_idx;
    logic        pending;

    // Issue one nibble whenever a fresh random bit is available; idle lines stay 0.
    always_comb begin
        issue   = (state_q == ISSUE) && rnd_valid;
        sb_x_s0 = '0;
        sb_x_s1 = '0;
        sb_r    = 1'b0;
        if (issue) begin
            sb_x_s0 = sh0_q[4*idx_q +: 4];
            sb_x_s1 = sh1_q[4*idx_q +: 4];
            sb_r    = rnd;
        end
    end

    // Controller next state, share capture and handshake outputs.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sh0_d     = sh0_q;
        sh1_d     = sh1_q;
        in_ready  = 1'b0;
        rnd_req   = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sh0_d   = in_s0;
                    sh1_d   = in_s1;
                    idx_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                rnd_req = 1'b1;
                if (issue) begin
                    idx_d = idx_q + nib_idx_t'(1);
                    if (idx_q == nib_idx_t'(NIBBLES - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!pending) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write each returning sbox result into the nibble slot its tag names.
    always_comb begin
        res0_d = res0_q;
        res1_d = res1_q;
        if (ret_vld) begin
            res0_d[4*ret_idx +: 4] = sb_y_s0;
            res1_d[4*ret_idx +: 4] = sb_y_s1;
        end
    end

    // State, index, share and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sh0_q   <= '0;
            sh1_q   <= '0;
            res0_q  <= '0;
            res1_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            res0_q  <= res0_d;
            res1_q  <= res1_d;
        end
    end

    sbox_tag_pipe #(
        .DEPTH(SBOX_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .push_vld(issue),
        .push_idx(idx_q),
        .ret_vld (ret_vld),
        .ret_idx (ret_idx),
        .pending (pending)
    );

    assign out_s0 = res0_q;
    assign out_s1 = res1_q;

endmodule

// File: doc/present_sbox_layer_seq.md
PRESENT_SBOX_LAYER_SEQ -- requirements
Module: present_sbox_layer_seq

Interface
REQ-001 Parameter SBOX_LAT, default 3, cycles from nibble presented on sb_x_* to its result valid on sb_y_*.
REQ-002 Parameter NIBBLES, default 16, nibbles per 64-bit state.
REQ-003 Clock and reset: one clock, clk; reset is asynchronous and active-high, rst.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  masked state offered.
REQ-007 in_ready  output  1  controller accepts state.
REQ-008 in_s0, in_s1  input  64 each  share 0 and share 1 of the state.
REQ-009 rnd_req  output  1  fresh random bit wanted this cycle.
REQ-010 rnd_valid  input  1  rnd holds a fresh bit.
REQ-011 rnd  input  1  fresh random bit.
REQ-012 sb_x_s0, sb_x_s1  output  4 each  nibble shares to the masked sbox; bit j drives sbox input xj.
REQ-013 sb_r  output  1  randomness to the sbox r port.
REQ-014 sb_y_s0, sb_y_s1  input  4 each  sbox result shares; bit j from Yj.
REQ-015 out_valid  output  1  result state available.
REQ-016 out_ready  input  1  consumer takes result.
REQ-017 out_s0, out_s1  output  64 each  result shares.

Function
REQ-018 States IDLE, ISSUE, DRAIN, DONE; in_ready=1 only in IDLE.
REQ-019 IDLE: on in_valid, capture in_s0/in_s1 (cycle 0), clear issue index, go ISSUE.
REQ-020 Nibble i = bits [4i+3:4i]; issued in order i=0..15.
REQ-021 ISSUE: rnd_req=1; one nibble issued per cycle with rnd_valid=1, sb_r=rnd in that same cycle; rnd_valid=0 gives a bubble, no issue.
REQ-022 After nibble 15 is issued, go DRAIN.
REQ-023 Tag pipeline of depth SBOX_LAT, carrying valid and 4-bit index, tracks in-flight nibbles; a nibble issued in cycle k is written into result nibble k-index at the end of cycle k+SBOX_LAT.
REQ-024 DRAIN: leave for DONE when no tag is valid.
REQ-025 DONE: out_valid=1; out_s0/out_s1 stable until out_valid&out_ready, then go IDLE.
REQ-026 No stalls: accept in cycle 0, issues in cycles 1..16, out_valid first high in cycle 20.
REQ-027 The two shares are never combined in any logic; share-0 and share-1 paths stay separate.
REQ-028 sb_x_s0, sb_x_s1 and sb_r are 0 in every cycle without an issue.
REQ-029 Share registers are only loaded in IDLE.
REQ-030 in_valid in non-IDLE states is ignored.

Reset
REQ-031 Reset applies asynchronously: state=IDLE, index=0, tag valids=0, in_ready=1 after reset, rnd_req=0, out_valid=0, out_s0=out_s1=0, sb_x_*=0, sb_r=0.
REQ-032 Reset mid-transaction discards in-flight nibbles; sbox results arriving after reset are not written.

Structure
REQ-033 Package present_dom_pkg holds SBOX_LAT, NIBBLES, the state enum and the nibble-index type.
REQ-034 Sub-module sbox_tag_pipe holds the valid/index delay line.
REQ-035 The masked sbox is instantiated outside this block.

Verification
REQ-036 in_s0=0x0123456789ABCDEF, in_s1=0, rnd_valid=1 always -> out_s0^out_s1=0xC56B90AD3EF84712, out_valid in cycle 20.
REQ-037 in_s0=in_s1=0xA5A5A5A5A5A5A5A5 (value 0) with random rnd -> out_s0^out_s1=0xCCCCCCCCCCCCCCCC.
REQ-038 rnd_valid toggling 1,0,1,0 -> same result as REQ-036; exactly 16 cycles with rnd_req&rnd_valid; sb_x_*=0 in bubbles.
REQ-039 out_ready held 0 for 5 cycles in DONE -> out_s0/out_s1 unchanged, in_ready=0, in_valid ignored.
REQ-040 rst pulse in cycle 8 of ISSUE -> all outputs at reset values; next transaction gives the REQ-036 result in cycle 20.
